// File: rtl/cba_pipe32_if.sv
// Operand/result handshake bundle for the pipelined 32-bit carry-bypass adder.
// The slave side is the adder; the master side is the operand source plus result consumer.
interface cba_pipe32_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cba_pipe32.sv
// 32-bit adder split into four 8-bit carry-bypass slices, one slice per stage,
// with the inter-slice carry registered. Valid/ready on both sides, 4-cycle latency.
module cba_pipe32 #(
    parameter int SLICE_W = 8,
    parameter int NSLICE  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    cba_pipe32_if.slave bus
);
    localparam int W      = SLICE_W;
    localparam int DATA_W = SLICE_W * NSLICE;

    // Ripple slice whose carry-out skips straight from cin when every bit propagates.
    function automatic logic [W:0] cba(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
        logic [W-1:0] p;
        logic [W-1:0] s;
        logic         c;
        p = x ^ y;
        c = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = p[i] ^ c;
            c    = (x[i] & y[i]) | (p[i] & c);
        end
        return {((&p) ? ci : c), s};
    endfunction

    function automatic logic sgn_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    logic              vld_p0, vld_p1, vld_p2, vld_p3, out_vld;
    logic              rdy_p0, rdy_p1, rdy_p2, rdy_p3, rdy_out;

    logic [DATA_W-1:0] a_p0, b_p0;
    logic              c_p0;
    logic [3*W-1:0]    a_p1, b_p1;
    logic [W-1:0]      s_p1;
    logic              c_p1;
    logic [2*W-1:0]    a_p2, b_p2;
    logic [2*W-1:0]    s_p2;
    logic              c_p2;
    logic [W-1:0]      a_p3, b_p3;
    logic [3*W-1:0]    s_p3;
    logic              c_p3;
    logic [DATA_W-1:0] sum_q;
    logic              cout_q, ovf_q;

    logic [W:0]        r0, r1, r2, r3;

    // A stage may load when empty or when the stage below takes its content.
    assign rdy_out = !out_vld || bus.out_ready;
    assign rdy_p3  = !vld_p3 || rdy_out;
    assign rdy_p2  = !vld_p2 || rdy_p3;
    assign rdy_p1  = !vld_p1 || rdy_p2;
    assign rdy_p0  = !vld_p0 || rdy_p1;

    assign r0 = cba(a_p0[W-1:0], b_p0[W-1:0], c_p0);
    assign r1 = cba(a_p1[W-1:0], b_p1[W-1:0], c_p1);
    assign r2 = cba(a_p2[W-1:0], b_p2[W-1:0], c_p2);
    assign r3 = cba(a_p3, b_p3, c_p3);

    assign bus.in_ready  = rdy_p0;
    assign bus.out_valid = out_vld;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Stage 0: input register, slice 0 consumes cin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            a_p0   <= '0;
            b_p0   <= '0;
            c_p0   <= 1'b0;
        end else if (rdy_p0) begin
            vld_p0 <= bus.in_valid;
            if (bus.in_valid) begin
                a_p0 <= bus.a;
                b_p0 <= bus.b;
                c_p0 <= bus.cin;
            end
        end
    end

    // Stage 1: byte 0 done, slice 1 pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            s_p1   <= '0;
            c_p1   <= 1'b0;
        end else if (rdy_p1) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                a_p1 <= a_p0[DATA_W-1:W];
                b_p1 <= b_p0[DATA_W-1:W];
                s_p1 <= r0[W-1:0];
                c_p1 <= r0[W];
            end
        end
    end

    // Stage 2: bytes 1:0 done, slice 2 pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            a_p2   <= '0;
            b_p2   <= '0;
            s_p2   <= '0;
            c_p2   <= 1'b0;
        end else if (rdy_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                a_p2 <= a_p1[3*W-1:W];
                b_p2 <= b_p1[3*W-1:W];
                s_p2 <= {r1[W-1:0], s_p1};
                c_p2 <= r1[W];
            end
        end
    end

    // Stage 3: bytes 2:0 done; the remaining top byte still carries a[31]/b[31]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p3 <= 1'b0;
            a_p3   <= '0;
            b_p3   <= '0;
            s_p3   <= '0;
            c_p3   <= 1'b0;
        end else if (rdy_p3) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                a_p3 <= a_p2[2*W-1:W];
                b_p3 <= b_p2[2*W-1:W];
                s_p3 <= {r2[W-1:0], s_p2};
                c_p3 <= r2[W];
            end
        end
    end

    // Output register: holds steady while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (rdy_out) begin
            out_vld <= vld_p3;
            if (vld_p3) begin
                sum_q  <= {r3[W-1:0], s_p3};
                cout_q <= r3[W];
                ovf_q  <= sgn_ovf(a_p3[W-1], b_p3[W-1], r3[W-1]);
            end
        end
    end
endmodule

// File: tb/tb_cba_pipe32.sv
// Directed and swept checks of cba_pipe32: arithmetic corners, latency,
// back-pressure, ordering and asynchronous reset with beats in flight.
module tb_cba_pipe32;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cba_pipe32_if bus ();

    cba_pipe32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t exp_q[$];
    exp_t em;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   prev_out_cyc = 0;
    int   last_out_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Result scoreboard: every transfer on the output side is matched in order.
    always begin
        @(negedge clk);
        #3;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 64'(bus.out_valid), 64'(0));
            end else begin
                em = exp_q.pop_front();
                check("out_sum", 64'(bus.sum), 64'(em.s));
                check("out_cout", 64'(bus.cout), 64'(em.c));
                check("out_ovf", 64'(bus.ovf), 64'(em.o));
            end
            n_out++;
            prev_out_cyc = last_out_cyc;
            last_out_cyc = cyc;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                        input logic [31:0] es, input logic ec, input logic eo);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        bus.cin      = tc;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        exp_q.push_back('{es, ec, eo});
        @(negedge clk);
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(cyc - acc_cyc), 64'(4));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int          nacc;
        int          idx;
        int          base;
        int          t;
        int          sent;
        logic        acc;
        logic        have;
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] full;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(negedge clk);

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        wait_valid("lat_wrap");
        drain();

        send(32'h00FF_FFFF, 32'hFDBA_CE01, 1'b0, 32'hFEBA_CE00, 1'b0, 1'b0);
        send(32'h00FF_FFFF, 32'h60D0_F0A1, 1'b0, 32'h61D0_F0A0, 1'b0, 1'b0);
        drain();
        check("b2b_gap", 64'(last_out_cyc - prev_out_cyc), 64'(1));

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        wait_valid("lat_ovf");
        drain();

        send(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        drain();

        // Back-pressure: consumer stalled while eight beats are offered
        bus.out_ready = 1'b0;
        #1;
        nacc = 0;
        idx  = 1;
        base = n_out;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = (idx <= 8);
            bus.a        = 32'(idx);
            bus.b        = 32'(idx);
            bus.cin      = 1'b0;
            acc          = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check("bp_hold_sum", 64'(bus.sum), 64'(2));
                check("bp_hold_cout", 64'(bus.cout), 64'(0));
            end
            @(posedge clk);
            if (acc) begin
                exp_q.push_back('{32'(2 * idx), 1'b0, 1'b0});
                idx++;
                nacc++;
            end
            @(negedge clk);
        end
        check("bp_accepts", 64'(nacc), 64'(5));
        check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        check("bp_out_valid", 64'(bus.out_valid), 64'(1));
        check("bp_first_sum", 64'(bus.sum), 64'(2));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        for (int i = idx; i <= 8; i++)
            send(32'(i), 32'(i), 1'b0, 32'(2 * i), 1'b0, 1'b0);
        drain();
        check("bp_count", 64'(n_out - base), 64'(8));

        // Asynchronous reset with three beats in flight and the output stalled
        bus.out_ready = 1'b0;
        #1;
        send(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);
        send(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);
        send(32'd5, 32'd6, 1'b1, 32'd12, 1'b0, 1'b0);
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rst_pre_valid", 64'(bus.out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus.out_valid), 64'(0));
        check("rst_async_sum", 64'(bus.sum), 64'(0));
        check("rst_async_cout", 64'(bus.cout), 64'(0));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("rst_rel_in_ready", 64'(bus.in_ready), 64'(1));
        base = n_out;
        repeat (8) @(negedge clk);
        check("rst_no_stale", 64'(n_out - base), 64'(0));
        send(32'd12345678, 32'd11111111, 1'b1, 32'd23456790, 1'b0, 1'b0);
        wait_valid("rst_next_lat");
        drain();

        // Random sweep against a behavioural a+b+cin model with random stalls
        sent = 0;
        have = 1'b0;
        base = n_out;
        ra   = '0;
        rb   = '0;
        rc   = 1'b0;
        for (int c = 0; c < 40000 && sent < 5536; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!have) begin
                ra   = $urandom;
                rb   = $urandom;
                rc   = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            bus.in_valid = 1'b1;
            bus.a        = ra;
            bus.b        = rb;
            bus.cin      = rc;
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            if (acc) begin
                full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
                exp_q.push_back('{full[31:0], full[32],
                                  (ra[31] == rb[31]) && (full[31] != ra[31])});
                sent++;
                have = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("sweep_sent", 64'(sent), 64'(5536));
        check("sweep_count", 64'(n_out - base), 64'(5536));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
